// File: rtl/board_link_pkg.sv
// Shared definitions for the inter-board Sudoku link (transmit and receive sides).
package board_link_pkg;

    localparam int         CELLS  = 81;
    localparam logic [3:0] HEADER = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RDWAIT,
        DRIVE,
        RELEASE,
        HOLD
    } link_state_t;

endpackage

// File: rtl/board_link_tx_sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous level from off-board.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/board_link_tx.sv
// Transmit side of the inter-board Sudoku link: header word plus CELLS cell words,
// one 4-phase request/ack handshake per word, with timeout abort.
module board_link_tx #(
    parameter int         CELLS       = board_link_pkg::CELLS,
    parameter logic [3:0] HEADER      = board_link_pkg::HEADER,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       request,
    input  logic       ack_in,
    output logic [3:0] data,
    output logic       valid,
    output logic [6:0] cell_addr,
    output logic       cell_rd,
    input  logic [3:0] cell_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import board_link_pkg::*;

    localparam int          TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0]  LAST = 7'(CELLS);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    link_state_t   state;
    logic [6:0]    widx;
    logic [TW-1:0] tcnt;
    logic          req_s;
    logic          ack_s;
    logic          timed_out;

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (request),
        .q   (req_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    // The counter holds TIMEOUT_CYC-1 on the last permitted waiting cycle.
    assign timed_out = (tcnt == TLIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            widx      <= '0;
            tcnt      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            cell_addr <= '0;
            cell_rd   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            cell_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_s) begin
                        widx  <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                // Address and strobe are registered on the way into LOAD so the
                // store sees them during LOAD and cell_data is ready in RDWAIT.
                LOAD: begin
                    if (widx == '0) begin
                        data  <= HEADER;
                        valid <= 1'b1;
                        tcnt  <= '0;
                        state <= DRIVE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    data  <= cell_data;
                    valid <= 1'b1;
                    tcnt  <= '0;
                    state <= DRIVE;
                end
                DRIVE: begin
                    if (ack_s) begin
                        valid <= 1'b0;
                        tcnt  <= '0;
                        state <= RELEASE;
                    end else if (timed_out) begin
                        valid <= 1'b0;
                        err   <= 1'b1;
                        state <= HOLD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        if (widx == LAST) begin
                            done  <= 1'b1;
                            state <= HOLD;
                        end else if (!req_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            widx      <= widx + 7'd1;
                            cell_addr <= widx;
                            cell_rd   <= 1'b1;
                            state     <= LOAD;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= HOLD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!req_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_link_tx.sv
// Directed/randomised bench for board_link_tx acting as the peer receiver and the board store.
module tb_board_link_tx;

    localparam int         NC  = 81;
    localparam logic [3:0] HDR = 4'hA;
    localparam int         TO  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       request;
    logic       ack_in;
    logic [3:0] data;
    logic       valid;
    logic [6:0] cell_addr;
    logic       cell_rd;
    logic [3:0] cell_data = '0;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] mem [0:127];
    logic [3:0] expq [$];

    always #5 clk = ~clk;

    // Board store with a 1-cycle read latency.
    always @(posedge clk) begin
        if (cell_rd) cell_data <= mem[cell_addr];
    end

    board_link_tx #(
        .CELLS       (NC),
        .HEADER      (HDR),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .ack_in    (ack_in),
        .data      (data),
        .valid     (valid),
        .cell_addr (cell_addr),
        .cell_rd   (cell_rd),
        .cell_data (cell_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 300);
        if (!valid) check("valid_rise_timeout", 32'(valid), 1);
    endtask

    // Peer side of one word: ack after dly cycles, wait for valid to drop,
    // release ack, then watch 3 more cycles for data stability and done.
    task automatic handshake(input int dly, output int done_cnt);
        logic [3:0] w;
        logic       stable;
        int         n;
        w      = data;
        stable = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (!valid || data !== w) stable = 1'b0;
        end
        ack_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (data !== w) stable = 1'b0;
        end while (valid && n < 300);
        if (valid) check("valid_drop_timeout", 32'(valid), 0);
        ack_in   = 1'b0;
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (data !== w) stable = 1'b0;
            if (done) done_cnt++;
        end
        check("data_stable", 32'(stable), 1);
    endtask

    // dly < 0 selects a random ack delay of 0..20 cycles per word.
    task automatic run_words(input int first, input int last, input int dly, input int first_gap);
        int cnt;
        int dc;
        int d;
        for (int k = first; k <= last; k++) begin
            wait_valid(cnt);
            if (k == first) check("req_to_valid", 32'(cnt), 32'(first_gap));
            else            check($sformatf("ack_to_valid%0d", k), 32'(cnt), 2);
            check($sformatf("word%0d", k), 32'(data), 32'(expq[k]));
            d = (dly < 0) ? int'($urandom_range(20, 0)) : dly;
            handshake(d, dc);
            check($sformatf("done_pulse%0d", k), 32'(dc), (k == NC) ? 1 : 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle", 32'(busy), 0);
    endtask

    task automatic build_expect_from_store();
        expq = {};
        expq.push_back(HDR);
        for (int a = 0; a < NC; a++) expq.push_back(mem[a]);
    endtask

    initial begin
        int  cnt;
        int  dc;
        int  n;
        logic any_valid;
        logic any_done;
        logic all_busy;

        rst     = 1'b1;
        request = 1'b0;
        ack_in  = 1'b0;
        for (int a = 0; a < 128; a++) mem[a] = 4'(a % 10);
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_addr", 32'(cell_addr), 0);
        check("rst_rd", 32'(cell_rd), 0);
        check("rst_flags", {29'd0, busy, done, err}, 0);
        rst = 1'b0;

        // ack with no frame in progress is ignored
        ack_in = 1'b1;
        any_valid = 1'b0;
        all_busy  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valid) any_valid = 1'b1;
            if (busy) all_busy = 1'b1;
        end
        ack_in = 1'b0;
        check("idle_ack_valid", 32'(any_valid), 0);
        check("idle_ack_busy", 32'(all_busy), 0);
        repeat (4) @(negedge clk);

        // Nominal frame: cells = addr % 10, ack 2 cycles after valid
        expq = {};
        expq.push_back(HDR);
        for (int a = 0; a < NC; a++) expq.push_back(4'(a % 10));
        request = 1'b1;
        run_words(0, NC, 2, 4);
        any_valid = 1'b0;
        any_done  = 1'b0;
        all_busy  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (valid) any_valid = 1'b1;
            if (done) any_done = 1'b1;
            if (!busy) all_busy = 1'b0;
        end
        check("hold_valid", 32'(any_valid), 0);
        check("hold_done", 32'(any_done), 0);
        check("hold_busy", 32'(all_busy), 1);
        request = 1'b0;
        wait_idle();

        // Random store contents and random ack delays
        for (int a = 0; a < NC; a++) mem[a] = 4'($urandom_range(9, 0));
        build_expect_from_store();
        request = 1'b1;
        run_words(0, NC, -1, 4);
        request = 1'b0;
        wait_idle();

        // Peer abort while word 40 is being driven
        for (int a = 0; a < NC; a++) mem[a] = 4'($urandom_range(9, 0));
        build_expect_from_store();
        request = 1'b1;
        run_words(0, 39, -1, 4);
        wait_valid(cnt);
        check("abort_word40", 32'(data), 32'(expq[40]));
        request = 1'b0;
        handshake(3, dc);
        check("abort_done", 32'(dc), 0);
        any_valid = 1'b0;
        any_done  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valid) any_valid = 1'b1;
            if (done) any_done = 1'b1;
        end
        check("abort_valid", 32'(any_valid), 0);
        check("abort_done_after", 32'(any_done), 0);
        check("abort_busy", 32'(busy), 0);

        // Timeout: word 5 is never acknowledged
        request = 1'b1;
        run_words(0, 4, 1, 4);
        wait_valid(cnt);
        check("to_word5", 32'(data), 32'(expq[5]));
        n = 1;
        while (valid && n < 200) begin
            @(negedge clk);
            if (valid) n++;
        end
        check("to_valid_cycles", 32'(n), TO);
        check("to_err", 32'(err), 1);
        check("to_busy", 32'(busy), 1);
        any_done  = 1'b0;
        any_valid = 1'b0;
        @(negedge clk);
        check("to_err_pulse", 32'(err), 0);
        repeat (8) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
            if (valid) any_valid = 1'b1;
        end
        check("to_no_done", 32'(any_done), 0);
        check("to_no_valid", 32'(any_valid), 0);
        request = 1'b0;
        wait_idle();

        // Reset while word 20 is valid
        for (int a = 0; a < NC; a++) mem[a] = 4'($urandom_range(9, 0));
        build_expect_from_store();
        request = 1'b1;
        run_words(0, 19, 2, 4);
        wait_valid(cnt);
        rst     = 1'b1;
        request = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 32'(valid), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_data", 32'(data), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Restart after reset, then hold request high after done
        request = 1'b1;
        run_words(0, NC, 3, 4);
        any_valid = 1'b0;
        all_busy  = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid) any_valid = 1'b1;
            if (!busy) all_busy = 1'b0;
        end
        check("held_no_frame", 32'(any_valid), 0);
        check("held_busy", 32'(all_busy), 1);
        request = 1'b0;
        wait_idle();
        request = 1'b1;
        run_words(0, 0, 1, 4);
        request = 1'b0;
        run_words(1, 1, 1, 2);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
